// File: rtl/stable_monitor_pkg.sv
// -----------------------------------------------------------------------------
// stable_monitor_pkg
// Shared types and helpers for the stable_monitor signal-stability checker.
//   run_state_e : per-channel tracking state (UNPRIMED until the first sample)
//   cap_rec_t   : first-violation capture record (widths sized to the largest
//                 supported configuration; users cast down to their widths)
//   sat_add     : saturating add against an explicit ceiling
//   popcount    : number of set bits in a violation vector
// -----------------------------------------------------------------------------
package stable_monitor_pkg;

   typedef enum logic [0:0] {
      UNPRIMED = 1'b0,
      PRIMED   = 1'b1
   } run_state_e;

   // Upper bounds for the fixed-width helpers and capture record.
   localparam int POP_W          = 256;
   localparam int CAP_CHAN_MAX_W = 16;
   localparam int CAP_VAL_MAX_W  = 64;

   typedef struct packed {
      logic                      valid;
      logic [CAP_CHAN_MAX_W-1:0] chan;
      logic [CAP_VAL_MAX_W-1:0]  old_val;
      logic [CAP_VAL_MAX_W-1:0]  new_val;
   } cap_rec_t;

   // a + b clamped to max_val; the 33-bit sum cannot overflow.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] max_val);
      logic [32:0] sum_s;
      sum_s = {1'b0, a} + {1'b0, b};
      if (sum_s > {1'b0, max_val}) begin
         sat_add = max_val;
      end else begin
         sat_add = sum_s[31:0];
      end
   endfunction

   function automatic logic [31:0] popcount(input logic [POP_W-1:0] v);
      logic [31:0] cnt_s;
      cnt_s = 32'd0;
      for (int i = 0; i < POP_W; i++) begin
         cnt_s = cnt_s + {31'd0, v[i]};
      end
      return cnt_s;
   endfunction

endpackage

// File: rtl/stable_monitor_chan.sv
// -----------------------------------------------------------------------------
// stable_monitor_chan
// One monitored channel: remembers the previous enabled sample, counts the
// current run length (saturating), and flags a change that ends a run shorter
// than MIN_HOLD. The very first run after reset is exempt because its true
// start is unknown.
// Ports:
//   clk, rst     clock / synchronous active-high reset
//   en           sample enable (0 freezes all tracking state)
//   din          channel value
//   stable_o     registered: last enabled sample equalled the previous one
//   viol_o       registered one-cycle violation pulse
//   viol_now_o   combinational: a violation is being registered this edge
//   prev_o       previous sample (only with STABLE_MONITOR_CAPTURE_EN)
// -----------------------------------------------------------------------------
module stable_monitor_chan
   import stable_monitor_pkg::*;
#(
   parameter int WIDTH    = 1,
   parameter int MIN_HOLD = 2,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic             stable_o,
   output logic             viol_o,
   output logic             viol_now_o
`ifdef STABLE_MONITOR_CAPTURE_EN
   ,
   output logic [WIDTH-1:0] prev_o
`endif
);

   localparam logic [31:0]      RUN_MAX    = 32'((64'd1 << CNT_W) - 64'd1);
   localparam logic [CNT_W-1:0] MIN_HOLD_C = CNT_W'(MIN_HOLD);

   run_state_e       state_r,     state_nxt_s;
   logic [WIDTH-1:0] prev_r,      prev_nxt_s;
   logic [CNT_W-1:0] run_len_r,   run_len_nxt_s;
   logic             first_run_r, first_run_nxt_s;
   logic             stable_r,    stable_nxt_s;
   logic             viol_r,      viol_nxt_s;

   // Next-state and next-output logic for the channel tracker.
   always_comb begin
      state_nxt_s     = state_r;
      prev_nxt_s      = prev_r;
      run_len_nxt_s   = run_len_r;
      first_run_nxt_s = first_run_r;
      stable_nxt_s    = stable_r;
      viol_nxt_s      = 1'b0;
      if (en) begin
         case (state_r)
            UNPRIMED: begin
               prev_nxt_s    = din;
               run_len_nxt_s = CNT_W'(1);
               state_nxt_s   = PRIMED;
               stable_nxt_s  = 1'b0;
            end
            PRIMED: begin
               if (din == prev_r) begin
                  run_len_nxt_s = CNT_W'(sat_add(32'(run_len_r), 32'd1, RUN_MAX));
                  stable_nxt_s  = 1'b1;
               end else begin
                  stable_nxt_s    = 1'b0;
                  viol_nxt_s      = !first_run_r && (run_len_r < MIN_HOLD_C);
                  prev_nxt_s      = din;
                  run_len_nxt_s   = CNT_W'(1);
                  first_run_nxt_s = 1'b0;
               end
            end
            default: begin
               state_nxt_s = UNPRIMED;
            end
         endcase
      end else begin
         viol_nxt_s = 1'b0;
      end
   end

   // Channel state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= UNPRIMED;
         prev_r      <= '0;
         run_len_r   <= '0;
         first_run_r <= 1'b1;
         stable_r    <= 1'b0;
         viol_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         prev_r      <= prev_nxt_s;
         run_len_r   <= run_len_nxt_s;
         first_run_r <= first_run_nxt_s;
         stable_r    <= stable_nxt_s;
         viol_r      <= viol_nxt_s;
      end
   end

   assign stable_o   = stable_r;
   assign viol_o     = viol_r;
   assign viol_now_o = viol_nxt_s;
`ifdef STABLE_MONITOR_CAPTURE_EN
   assign prev_o     = prev_r;
`endif

endmodule

// File: rtl/stable_monitor.sv
// -----------------------------------------------------------------------------
// stable_monitor
// Multi-channel signal-stability checker. Each channel is tracked by a
// stable_monitor_chan instance; this level aggregates violations into a
// sticky error flag and a saturating violation counter.
// Optional build macro STABLE_MONITOR_CAPTURE_EN adds a first-violation
// capture (lowest-index violating channel, its old and new value).
// Ports:
//   clk, rst       clock / synchronous active-high reset (highest priority)
//   en             sample enable
//   din            CHANNELS*WIDTH values, channel c at [c*WIDTH +: WIDTH]
//   clr_err        synchronous clear of err_sticky_o, viol_cnt_o (and capture)
//   stable_o       per-channel sample-to-sample stability
//   viol_o         per-channel one-cycle violation pulse
//   err_sticky_o   set on any violation until clr_err/rst
//   viol_cnt_o     saturating total violation count
//   cap_valid_o, cap_chan_o, cap_old_o, cap_new_o   (capture build only)
// -----------------------------------------------------------------------------
module stable_monitor
   import stable_monitor_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int WIDTH    = 1,
   parameter int MIN_HOLD = 2,
   parameter int CNT_W    = 8,
   localparam int CHAN_IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [CHANNELS*WIDTH-1:0] din,
   input  logic                      clr_err,
   output logic [CHANNELS-1:0]       stable_o,
   output logic [CHANNELS-1:0]       viol_o,
   output logic                      err_sticky_o,
   output logic [CNT_W-1:0]          viol_cnt_o
`ifdef STABLE_MONITOR_CAPTURE_EN
   ,
   output logic                      cap_valid_o,
   output logic [CHAN_IDX_W-1:0]     cap_chan_o,
   output logic [WIDTH-1:0]          cap_old_o,
   output logic [WIDTH-1:0]          cap_new_o
`endif
);

   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   logic [CHANNELS-1:0] viol_now_s;
   logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
   logic                err_r, err_nxt_s;
`ifdef STABLE_MONITOR_CAPTURE_EN
   logic [CHANNELS*WIDTH-1:0] prev_all_s;
`endif

   for (genvar c = 0; c < CHANNELS; c++) begin : chan_g
      stable_monitor_chan #(
         .WIDTH    (WIDTH),
         .MIN_HOLD (MIN_HOLD),
         .CNT_W    (CNT_W)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .en         (en),
         .din        (din[c*WIDTH +: WIDTH]),
         .stable_o   (stable_o[c]),
         .viol_o     (viol_o[c]),
         .viol_now_o (viol_now_s[c])
`ifdef STABLE_MONITOR_CAPTURE_EN
         ,
         .prev_o     (prev_all_s[c*WIDTH +: WIDTH])
`endif
      );
   end

   // Aggregate this edge's violations; a clear beats a simultaneous violation.
   always_comb begin
      cnt_nxt_s = cnt_r;
      err_nxt_s = err_r;
      if (clr_err) begin
         cnt_nxt_s = '0;
         err_nxt_s = 1'b0;
      end else if (|viol_now_s) begin
         cnt_nxt_s = CNT_W'(sat_add(32'(cnt_r), popcount(POP_W'(viol_now_s)), CNT_MAX));
         err_nxt_s = 1'b1;
      end else begin
         cnt_nxt_s = cnt_r;
         err_nxt_s = err_r;
      end
   end

   // Error flag and violation counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
         err_r <= 1'b0;
      end else begin
         cnt_r <= cnt_nxt_s;
         err_r <= err_nxt_s;
      end
   end

   assign viol_cnt_o   = cnt_r;
   assign err_sticky_o = err_r;

`ifdef STABLE_MONITOR_CAPTURE_EN
   cap_rec_t cap_r, cap_nxt_s;
   logic     hit_s;
   logic [CAP_CHAN_MAX_W-1:0] idx_s;
   logic [WIDTH-1:0]          old_s, new_s;

   // Pick the lowest-index violating channel; scanning downwards lets the
   // lowest index overwrite the higher ones.
   always_comb begin
      hit_s = 1'b0;
      idx_s = '0;
      old_s = '0;
      new_s = '0;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         hit_s = hit_s | viol_now_s[c];
         idx_s = viol_now_s[c] ? CAP_CHAN_MAX_W'(c) : idx_s;
         old_s = viol_now_s[c] ? prev_all_s[c*WIDTH +: WIDTH] : old_s;
         new_s = viol_now_s[c] ? din[c*WIDTH +: WIDTH] : new_s;
      end
   end

   // Capture only the first violation since the last rst/clr_err.
   always_comb begin
      cap_nxt_s = cap_r;
      if (clr_err) begin
         cap_nxt_s = '0;
      end else if (!cap_r.valid && hit_s) begin
         cap_nxt_s.valid   = 1'b1;
         cap_nxt_s.chan    = idx_s;
         cap_nxt_s.old_val = CAP_VAL_MAX_W'(old_s);
         cap_nxt_s.new_val = CAP_VAL_MAX_W'(new_s);
      end else begin
         cap_nxt_s = cap_r;
      end
   end

   // Capture record register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_r <= '0;
      end else begin
         cap_r <= cap_nxt_s;
      end
   end

   assign cap_valid_o = cap_r.valid;
   assign cap_chan_o  = CHAN_IDX_W'(cap_r.chan);
   assign cap_old_o   = WIDTH'(cap_r.old_val);
   assign cap_new_o   = WIDTH'(cap_r.new_val);
`endif

endmodule
